// File: rtl/axi4_wr_mix_interconnect_m2s_a1_if.sv
// AXI4 write-only channel bundle (AW/W/B) shared by upstream ports and the
// single downstream port of the write interconnect.
interface axi_inf #(
  parameter int IDSIZE     = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic                    axi_aclk;
  logic                    axi_aresetn;

  logic [IDSIZE-1:0]       axi_awid;
  logic [ADDR_WIDTH-1:0]   axi_awaddr;
  logic [7:0]              axi_awlen;
  logic                    axi_awvalid;
  logic                    axi_awready;

  logic [DATA_WIDTH-1:0]   axi_wdata;
  logic [DATA_WIDTH/8-1:0] axi_wstrb;
  logic                    axi_wlast;
  logic                    axi_wvalid;
  logic                    axi_wready;

  logic [IDSIZE-1:0]       axi_bid;
  logic [1:0]              axi_bresp;
  logic                    axi_bvalid;
  logic                    axi_bready;

  // Initiator side of a write channel (drives AW/W, accepts B).
  modport master_wr (
    input  axi_aclk, axi_aresetn,
    output axi_awid, axi_awaddr, axi_awlen, axi_awvalid,
    input  axi_awready,
    output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    input  axi_wready,
    input  axi_bid, axi_bresp, axi_bvalid,
    output axi_bready
  );

  // Target side of a write channel (accepts AW/W, drives B).
  modport slaver_wr (
    input  axi_aclk, axi_aresetn,
    input  axi_awid, axi_awaddr, axi_awlen, axi_awvalid,
    output axi_awready,
    input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    output axi_wready,
    output axi_bid, axi_bresp, axi_bvalid,
    input  axi_bready
  );
endinterface

// File: rtl/axi4_wr_mix_interconnect_m2s_a1.sv
// N-to-1 AXI4 write interconnect. AW is arbitrated round-robin through a
// two-state lock FSM; each granted port index is queued in an order FIFO that
// steers the W channel; B is routed back by the low NSIZE bits of bid.
// Optional debug tracking registers: define AXI4_WR_MIX_TRACK_EN.
module axi4_wr_mix_interconnect_m2s_a1 #(
  parameter int NUM         = 8,
  parameter int ORDER_DEPTH = 4
) (
  axi_inf.slaver_wr slaver [NUM-1:0],
  axi_inf.master_wr master
);
  localparam int NSIZE = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int MID   = $bits(master.axi_awid);
  localparam int SID   = MID - NSIZE;
  localparam int AW    = $bits(master.axi_awaddr);
  localparam int DW    = $bits(master.axi_wdata);
  localparam int PW    = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;
  localparam int CW    = $clog2(ORDER_DEPTH + 1);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} aw_state_e;

  logic clk;
  logic rst_n;
  assign clk   = master.axi_aclk;
  assign rst_n = master.axi_aresetn;

  // Flattened copies of the upstream ports so they can be indexed at run time.
  logic [NUM-1:0]  s_awvalid, s_wvalid, s_wlast, s_bready;
  logic [NUM-1:0]  s_awready, s_wready, s_bvalid;
  logic [SID-1:0]  s_awid   [NUM];
  logic [AW-1:0]   s_awaddr [NUM];
  logic [7:0]      s_awlen  [NUM];
  logic [DW-1:0]   s_wdata  [NUM];
  logic [DW/8-1:0] s_wstrb  [NUM];

  aw_state_e       state_q;
  logic [NSIZE-1:0] grant_q, last_q;
  logic [NSIZE-1:0] fifo_q [ORDER_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   cnt_q;

  logic             rr_found;
  logic [NSIZE-1:0] rr_idx;
  logic [NSIZE-1:0] head;
  logic             fifo_empty, fifo_full;
  logic             m_awvalid, m_wvalid, aw_hs, w_pop;
  logic [NSIZE-1:0] bk;
  logic             bk_valid;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(ORDER_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head       = fifo_q[rd_ptr_q];
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CW'(ORDER_DEPTH));

  // Round-robin search starting just after the last winner, wrapping to 0.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int i = 1; i <= NUM; i++) begin
      if (!rr_found && s_awvalid[(int'(last_q) + i) % NUM]) begin
        rr_found = 1'b1;
        rr_idx   = NSIZE'((int'(last_q) + i) % NUM);
      end
    end
  end

  // AW lock FSM: grant in IDLE, hold the mux in LOCK until the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= NSIZE'(NUM - 1);
    end else begin
      case (state_q)
        IDLE: if (rr_found && !fifo_full) begin
          grant_q <= rr_idx;
          state_q <= LOCK;
        end
        LOCK: if (aw_hs) begin
          last_q  <= grant_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Order FIFO pointers and occupancy; storage itself needs no reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (aw_hs) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (w_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({aw_hs, w_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Order FIFO storage: one port index per accepted AW burst.
  always_ff @(posedge clk) begin
    if (aw_hs) fifo_q[wr_ptr_q] <= grant_q;
  end

  // Downstream AW mux, driven only while a grant is locked.
  assign m_awvalid          = (state_q == LOCK) && s_awvalid[grant_q];
  assign aw_hs              = m_awvalid && master.axi_awready;
  assign master.axi_awvalid = m_awvalid;
  assign master.axi_awid    = {s_awid[grant_q], grant_q};
  assign master.axi_awaddr  = s_awaddr[grant_q];
  assign master.axi_awlen   = s_awlen[grant_q];

  // Downstream W mux follows the FIFO head; nothing passes while it is empty.
  assign m_wvalid          = !fifo_empty && s_wvalid[head];
  assign w_pop             = m_wvalid && master.axi_wready && s_wlast[head];
  assign master.axi_wvalid = m_wvalid;
  assign master.axi_wdata  = s_wdata[head];
  assign master.axi_wstrb  = s_wstrb[head];
  assign master.axi_wlast  = s_wlast[head];

  // B demux by the port tag in the low id bits; unknown tags are drained.
  assign bk                = master.axi_bid[NSIZE-1:0];
  assign bk_valid          = (int'(bk) < NUM);
  assign master.axi_bready = bk_valid ? s_bready[bk] : 1'b1;

  for (genvar gi = 0; gi < NUM; gi++) begin : g_port
    if ($bits(slaver[gi].axi_awid) != SID) begin : g_idsize_bad
      $error("slaver IDSIZE + NSIZE must equal master IDSIZE");
    end
    assign s_awvalid[gi] = slaver[gi].axi_awvalid;
    assign s_awid[gi]    = slaver[gi].axi_awid;
    assign s_awaddr[gi]  = slaver[gi].axi_awaddr;
    assign s_awlen[gi]   = slaver[gi].axi_awlen;
    assign s_wvalid[gi]  = slaver[gi].axi_wvalid;
    assign s_wdata[gi]   = slaver[gi].axi_wdata;
    assign s_wstrb[gi]   = slaver[gi].axi_wstrb;
    assign s_wlast[gi]   = slaver[gi].axi_wlast;
    assign s_bready[gi]  = slaver[gi].axi_bready;

    assign s_awready[gi] = (state_q == LOCK) && (grant_q == NSIZE'(gi)) && master.axi_awready;
    assign s_wready[gi]  = !fifo_empty && (head == NSIZE'(gi)) && master.axi_wready;
    assign s_bvalid[gi]  = master.axi_bvalid && bk_valid && (bk == NSIZE'(gi));

    assign slaver[gi].axi_awready = s_awready[gi];
    assign slaver[gi].axi_wready  = s_wready[gi];
    assign slaver[gi].axi_bvalid  = s_bvalid[gi];
    assign slaver[gi].axi_bid     = master.axi_bid[MID-1:NSIZE];
    assign slaver[gi].axi_bresp   = master.axi_bresp;
  end

`ifdef AXI4_WR_MIX_TRACK_EN
  (* dont_touch = "true" *) logic [MID-1:0] track_awid_q, track_bid_q;
  (* dont_touch = "true" *) logic [SID-1:0] slaver0_track_awid_q, slaver0_track_bid_q;
  (* dont_touch = "true" *) logic [SID-1:0] slaver1_track_awid_q, slaver1_track_bid_q;

  // Debug capture of the most recent ids seen on each handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      track_awid_q         <= '0;
      track_bid_q          <= '0;
      slaver0_track_awid_q <= '0;
      slaver0_track_bid_q  <= '0;
      slaver1_track_awid_q <= '0;
      slaver1_track_bid_q  <= '0;
    end else begin
      if (aw_hs) track_awid_q <= master.axi_awid;
      if (master.axi_bvalid && master.axi_bready) track_bid_q <= master.axi_bid;
      if (s_awvalid[0] && s_awready[0]) slaver0_track_awid_q <= s_awid[0];
      if (s_bvalid[0] && s_bready[0]) slaver0_track_bid_q <= master.axi_bid[MID-1:NSIZE];
      if (s_awvalid[1] && s_awready[1]) slaver1_track_awid_q <= s_awid[1];
      if (s_bvalid[1] && s_bready[1]) slaver1_track_bid_q <= master.axi_bid[MID-1:NSIZE];
    end
  end
`else
  // Tracking disabled: no debug state is built.
`endif

endmodule
